// File: rtl/team_06_uart_tx_arbiter_if.sv
// Byte-source / UART-TX bundle shared by the team_06 transmit arbiter.
// The arbiter sits on the slave side; sources and the UART form the master side.
interface team_06_uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic              en;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              timeout_pulse;

  modport slave (
    input  en, req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_data, tx_valid, grant, busy, timeout_pulse
  );

  modport master (
    output en, req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid, grant, busy, timeout_pulse
  );
endinterface

// File: rtl/team_06_uart_tx_arbiter.sv
// Round-robin arbiter locking the UART TX byte port to one source per packet.
// A grant ends on the source's last byte, after MAX_LEN bytes, or after TIMEOUT idle cycles.
module team_06_uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 64
) (
  input logic                     clk,
  input logic                     nrst,
  team_06_uart_tx_arbiter_if.slave bus
);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [PTR_W-1:0] owner_reg, owner_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [NREQ-1:0]  grant_reg, grant_next;
  logic [7:0]       byte_cnt_reg, byte_cnt_next;
  logic [7:0]       idle_cnt_reg, idle_cnt_next;
  logic             timeout_pulse_reg, timeout_pulse_next;

  logic             active;
  logic             owner_valid;
  logic             owner_last;
  logic             xfer;
  logic             rel;
  logic             pick_found;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] owner_inc;

  // Passthrough is forced quiet while reset is held, even if the registers still say LOCK.
  assign active       = nrst && (state_reg == LOCK);
  assign owner_valid  = bus.req_valid[owner_reg];
  assign owner_last   = bus.req_last[owner_reg];
  assign bus.tx_valid = active && owner_valid;
  assign bus.tx_data  = active ? bus.req_data[{owner_reg, 3'b000} +: 8] : 8'h00;
  assign xfer         = bus.tx_valid && bus.tx_ready;
  assign owner_inc    = (owner_reg == PTR_W'(NREQ - 1)) ? '0 : owner_reg + 1'b1;

  assign bus.grant         = grant_reg;
  assign bus.busy          = (state_reg == LOCK);
  assign bus.timeout_pulse = timeout_pulse_reg;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
    assign bus.req_ready[gi] = active && (owner_reg == PTR_W'(gi)) && bus.tx_ready;
  end

  // Walk downwards so the candidate closest to ptr is the one left standing.
  always_comb begin
    int cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = (int'(ptr_reg) + k) % NREQ;
      if (bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(cand);
      end
    end
  end

  always_comb begin
    state_next         = state_reg;
    owner_next         = owner_reg;
    ptr_next           = ptr_reg;
    grant_next         = grant_reg;
    byte_cnt_next      = byte_cnt_reg;
    idle_cnt_next      = idle_cnt_reg;
    timeout_pulse_next = 1'b0;
    rel                = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.en && pick_found) begin
          state_next           = LOCK;
          owner_next           = pick_idx;
          grant_next           = '0;
          grant_next[pick_idx] = 1'b1;
          byte_cnt_next        = 8'd0;
          idle_cnt_next        = 8'd0;
        end
      end
      LOCK: begin
        if (xfer) begin
          if (owner_last || (byte_cnt_reg == 8'(MAX_LEN - 1))) begin
            rel = 1'b1;
          end else begin
            byte_cnt_next = byte_cnt_reg + 8'd1;
            idle_cnt_next = 8'd0;
          end
        end else if (!owner_valid) begin
          if (idle_cnt_reg == 8'(TIMEOUT - 1)) begin
            rel                = 1'b1;
            timeout_pulse_next = 1'b1;
          end else begin
            idle_cnt_next = idle_cnt_reg + 8'd1;
          end
        end
        // Owner valid but UART stalled: everything holds, stall is not idleness.
        if (rel) begin
          state_next = IDLE;
          grant_next = '0;
          ptr_next   = owner_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg         <= IDLE;
      owner_reg         <= '0;
      ptr_reg           <= '0;
      grant_reg         <= '0;
      byte_cnt_reg      <= 8'd0;
      idle_cnt_reg      <= 8'd0;
      timeout_pulse_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      owner_reg         <= owner_next;
      ptr_reg           <= ptr_next;
      grant_reg         <= grant_next;
      byte_cnt_reg      <= byte_cnt_next;
      idle_cnt_reg      <= idle_cnt_next;
      timeout_pulse_reg <= timeout_pulse_next;
    end
  end
endmodule
